// File: rtl/noekeon_pkg.sv
// rtl/noekeon_pkg.sv - shared state encoding and default round parameters for the Noekeon controller
package noekeon_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_RUN  = 3'd1,
    KEY_LAST = 3'd2,
    ENC_RUN  = 3'd3,
    ENC_LAST = 3'd4,
    DEC_RUN  = 3'd5,
    DEC_LAST = 3'd6,
    HOLD     = 3'd7
  } ctrlState_e;

  localparam int ROUNDS_DEF = 16;
  localparam int RN_W_DEF   = 5;

  // Counter value on which a forward run hands over to its LAST state
  function automatic int lastRoundIdx(input int rounds);
    return rounds - 1;
  endfunction

  localparam int LAST_ROUND_DEF = lastRoundIdx(ROUNDS_DEF);

endpackage

// File: rtl/noekeon_round_cnt.sv
// rtl/noekeon_round_cnt.sv - loadable up/down round counter; load wins over inc, inc over dec
module noekeon_round_cnt #(
  parameter int RN_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic [RN_W-1:0] loadValue,
  input  logic            inc,
  input  logic            dec,
  output logic [RN_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (inc) begin
      count <= count + 1'b1;
    end else if (dec) begin
      count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/noekeon_round_ctrl.sv
// rtl/noekeon_round_ctrl.sv - Noekeon round-sequencing controller with key tracking and output hold
// Optional abort support is built when NOEKEON_CTRL_ABORT_EN is defined.
module noekeon_round_ctrl
  import noekeon_pkg::*;
#(
  parameter int ROUNDS = ROUNDS_DEF,
  parameter int RN_W   = RN_W_DEF
) (
  input  logic            inClk,
  input  logic            inReset,
  input  logic            inMode,
  input  logic            inDecipher,
  input  logic            inKeyWr,
  input  logic            inDataWr,
  input  logic            inOutAck,
  input  logic            inAbort,
  output logic            outBusy,
  output logic            outKeyWrExt,
  output logic            outKeyWrCipher,
  output logic            outDataWrKey,
  output logic            outDataWrExt,
  output logic            outDataWrInt,
  output logic [RN_W-1:0] outRoundNumber,
  output logic            outRegOutDataWr,
  output logic            outIntDecipher,
  output logic            outResetKey,
  output logic            outKeyReady,
  output logic            outValid
);

  localparam logic [RN_W-1:0] LAST_IDX   = RN_W'(lastRoundIdx(ROUNDS));
  localparam logic [RN_W-1:0] ROUNDS_VAL = RN_W'(ROUNDS);
  localparam logic [RN_W-1:0] ONE_VAL    = RN_W'(1);

  ctrlState_e      state, nextState;
  logic            keyReady, decipher;
  logic            cntLoad, cntInc, cntDec;
  logic [RN_W-1:0] cntLoadValue;
  logic            abortNow;

`ifdef NOEKEON_CTRL_ABORT_EN
  assign abortNow = inAbort && (state != IDLE);
`else
  logic unusedAbort;
  assign unusedAbort = inAbort;
  assign abortNow    = 1'b0;
`endif

  noekeon_round_cnt #(.RN_W(RN_W)) uRoundCnt (
    .clk       (inClk),
    .reset     (inReset),
    .load      (cntLoad),
    .loadValue (cntLoadValue),
    .inc       (cntInc),
    .dec       (cntDec),
    .count     (outRoundNumber)
  );

  always_ff @(posedge inClk) begin
    if (inReset) begin
      state    <= IDLE;
      keyReady <= 1'b0;
      decipher <= 1'b0;
    end else begin
      state <= nextState;
      if (outKeyWrExt || outKeyWrCipher) keyReady <= 1'b1;
      if (outDataWrKey) begin
        keyReady <= 1'b0;
        decipher <= 1'b0;
      end
      if (outDataWrExt) decipher <= inDecipher;
    end
  end

  always_comb begin
    nextState       = state;
    cntLoad         = 1'b0;
    cntLoadValue    = '0;
    cntInc          = 1'b0;
    cntDec          = 1'b0;
    outKeyWrExt     = 1'b0;
    outKeyWrCipher  = 1'b0;
    outDataWrKey    = 1'b0;
    outDataWrExt    = 1'b0;
    outDataWrInt    = 1'b0;
    outRegOutDataWr = 1'b0;
    outValid        = 1'b0;

    case (state)
      IDLE: begin
        // A key request always shadows a simultaneous data request
        if (inKeyWr) begin
          if (!inMode) begin
            outKeyWrExt = 1'b1;
          end else begin
            outDataWrKey = 1'b1;
            cntLoad      = 1'b1;
            nextState    = KEY_RUN;
          end
        end else if (inDataWr && keyReady) begin
          outDataWrExt = 1'b1;
          cntLoad      = 1'b1;
          if (inDecipher) begin
            cntLoadValue = ROUNDS_VAL;
            nextState    = DEC_RUN;
          end else begin
            nextState = ENC_RUN;
          end
        end
      end
      KEY_RUN, ENC_RUN: begin
        outDataWrInt = 1'b1;
        cntInc       = 1'b1;
        if (outRoundNumber == LAST_IDX) begin
          nextState = (state == KEY_RUN) ? KEY_LAST : ENC_LAST;
        end
      end
      DEC_RUN: begin
        outDataWrInt = 1'b1;
        cntDec       = 1'b1;
        if (outRoundNumber == ONE_VAL) nextState = DEC_LAST;
      end
      KEY_LAST: begin
        outKeyWrCipher = 1'b1;
        nextState      = IDLE;
      end
      ENC_LAST, DEC_LAST: begin
        outRegOutDataWr = 1'b1;
        nextState       = HOLD;
      end
      HOLD: begin
        outValid = 1'b1;
        if (inOutAck) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    if (abortNow) begin
      nextState    = IDLE;
      cntLoad      = 1'b1;
      cntLoadValue = '0;
      cntInc       = 1'b0;
      cntDec       = 1'b0;
    end

    // Reset and abort cycles must not disturb any datapath register
    if (abortNow || inReset) begin
      outKeyWrExt     = 1'b0;
      outKeyWrCipher  = 1'b0;
      outDataWrKey    = 1'b0;
      outDataWrExt    = 1'b0;
      outDataWrInt    = 1'b0;
      outRegOutDataWr = 1'b0;
    end
  end

  assign outResetKey    = inReset || ((state == IDLE) && inKeyWr && inMode);
  assign outBusy        = (state != IDLE);
  assign outKeyReady    = keyReady;
  assign outIntDecipher = decipher;

endmodule

// File: tb/tb_noekeon_round_ctrl.sv
// tb/tb_noekeon_round_ctrl.sv - directed self-checking bench for noekeon_round_ctrl (ROUNDS = 16)
// Abort scenarios are exercised when NOEKEON_CTRL_ABORT_EN is defined.
module tb_noekeon_round_ctrl;

  localparam int ROUNDS = 16;
  localparam int RN_W   = 5;

  logic            inClk = 1'b0;
  logic            inReset, inMode, inDecipher, inKeyWr, inDataWr, inOutAck, inAbort;
  logic            outBusy, outKeyWrExt, outKeyWrCipher, outDataWrKey, outDataWrExt, outDataWrInt;
  logic [RN_W-1:0] outRoundNumber;
  logic            outRegOutDataWr, outIntDecipher, outResetKey, outKeyReady, outValid;
  logic [15:0]     allOut;

  int checkCount = 0;
  int passCount  = 0;

  noekeon_round_ctrl #(.ROUNDS(ROUNDS), .RN_W(RN_W)) dut (
    .inClk           (inClk),
    .inReset         (inReset),
    .inMode          (inMode),
    .inDecipher      (inDecipher),
    .inKeyWr         (inKeyWr),
    .inDataWr        (inDataWr),
    .inOutAck        (inOutAck),
    .inAbort         (inAbort),
    .outBusy         (outBusy),
    .outKeyWrExt     (outKeyWrExt),
    .outKeyWrCipher  (outKeyWrCipher),
    .outDataWrKey    (outDataWrKey),
    .outDataWrExt    (outDataWrExt),
    .outDataWrInt    (outDataWrInt),
    .outRoundNumber  (outRoundNumber),
    .outRegOutDataWr (outRegOutDataWr),
    .outIntDecipher  (outIntDecipher),
    .outResetKey     (outResetKey),
    .outKeyReady     (outKeyReady),
    .outValid        (outValid)
  );

  always #5 inClk = ~inClk;

  assign allOut = {outBusy, outKeyWrExt, outKeyWrCipher, outDataWrKey, outDataWrExt, outDataWrInt,
                   outRegOutDataWr, outIntDecipher, outResetKey, outKeyReady, outValid, outRoundNumber};

  task automatic cyc();
    @(posedge inClk);
    #1;
  endtask

  task automatic test_reset();
    inReset = 1'b1; inKeyWr = 1'b1; inMode = 1'b0;
    cyc(); cyc();
    #1;
    checkCount++;
    if (outResetKey !== 1'b1) $display("FAIL reset_resetkey: got %b expected 1", outResetKey); else passCount++;
    checkCount++;
    if (outKeyWrExt !== 1'b0) $display("FAIL reset_no_strobe: got %b expected 0", outKeyWrExt); else passCount++;
    inReset = 1'b0; inKeyWr = 1'b0;
    cyc(); #1;
    checkCount++;
    if (allOut !== 16'h0) $display("FAIL after_reset_outputs: got %h expected 0000", allOut); else passCount++;
  endtask

  task automatic test_data_no_key();
    cyc();
    inDataWr = 1'b1; inDecipher = 1'b0; #1;
    checkCount++;
    if (outDataWrExt !== 1'b0) $display("FAIL nokey_datawrext: got %b expected 0", outDataWrExt); else passCount++;
    cyc(); inDataWr = 1'b0; #1;
    checkCount++;
    if (outBusy !== 1'b0) $display("FAIL nokey_busy: got %b expected 0", outBusy); else passCount++;
  endtask

  task automatic test_direct_key();
    cyc();
    inKeyWr = 1'b1; inMode = 1'b0; #1;
    checkCount++;
    if ({outKeyWrExt, outResetKey, outDataWrKey} !== 3'b100)
      $display("FAIL dkey_strobes: got %b expected 100", {outKeyWrExt, outResetKey, outDataWrKey}); else passCount++;
    cyc(); inKeyWr = 1'b0; #1;
    checkCount++;
    if ({outKeyReady, outBusy} !== 2'b10)
      $display("FAIL dkey_ready: got %b expected 10", {outKeyReady, outBusy}); else passCount++;
  endtask

  task automatic test_key_priority();
    cyc();
    inKeyWr = 1'b1; inMode = 1'b0; inDataWr = 1'b1; inDecipher = 1'b0; #1;
    checkCount++;
    if ({outKeyWrExt, outDataWrExt} !== 2'b10)
      $display("FAIL prio_strobes: got %b expected 10", {outKeyWrExt, outDataWrExt}); else passCount++;
    cyc(); inKeyWr = 1'b0; inDataWr = 1'b0; #1;
    checkCount++;
    if (outBusy !== 1'b0) $display("FAIL prio_busy: got %b expected 0", outBusy); else passCount++;
  endtask

  task automatic test_encrypt();
    cyc();
    inDataWr = 1'b1; inDecipher = 1'b0; #1;
    checkCount++;
    if (outDataWrExt !== 1'b1) $display("FAIL enc_datawrext: got %b expected 1", outDataWrExt); else passCount++;
    cyc(); inDataWr = 1'b0;
    for (int i = 0; i < ROUNDS; i++) begin
      #1;
      checkCount++;
      if ({outDataWrInt, outIntDecipher, outRoundNumber} !== {2'b10, RN_W'(i)})
        $display("FAIL enc_run%0d: got %b_%0d expected 10_%0d", i, {outDataWrInt, outIntDecipher}, outRoundNumber, i);
      else passCount++;
      cyc();
    end
    #1;
    checkCount++;
    if ({outRegOutDataWr, outDataWrInt, outRoundNumber} !== {2'b10, RN_W'(ROUNDS)})
      $display("FAIL enc_last: got %b_%0d expected 10_16", {outRegOutDataWr, outDataWrInt}, outRoundNumber);
    else passCount++;
    cyc();
    for (int i = 0; i < 10; i++) begin
      inDataWr = 1'b1; #1;
      checkCount++;
      if ({outValid, outDataWrExt, outBusy} !== 3'b101)
        $display("FAIL enc_hold%0d: got %b expected 101", i, {outValid, outDataWrExt, outBusy}); else passCount++;
      cyc();
    end
    inOutAck = 1'b1; #1;
    checkCount++;
    if ({outValid, outDataWrExt} !== 2'b10)
      $display("FAIL enc_ack: got %b expected 10", {outValid, outDataWrExt}); else passCount++;
    cyc(); inOutAck = 1'b0; inDataWr = 1'b0; #1;
    checkCount++;
    if ({outBusy, outValid} !== 2'b00)
      $display("FAIL enc_idle: got %b expected 00", {outBusy, outValid}); else passCount++;
  endtask

  task automatic test_decrypt();
    cyc();
    inDataWr = 1'b1; inDecipher = 1'b1; #1;
    checkCount++;
    if (outDataWrExt !== 1'b1) $display("FAIL dec_datawrext: got %b expected 1", outDataWrExt); else passCount++;
    cyc(); inDataWr = 1'b0; inDecipher = 1'b0;
    for (int i = 0; i < ROUNDS; i++) begin
      #1;
      checkCount++;
      if ({outDataWrInt, outIntDecipher, outRoundNumber} !== {2'b11, RN_W'(ROUNDS - i)})
        $display("FAIL dec_run%0d: got %b_%0d expected 11_%0d", i, {outDataWrInt, outIntDecipher}, outRoundNumber, ROUNDS - i);
      else passCount++;
      cyc();
    end
    #1;
    checkCount++;
    if ({outRegOutDataWr, outIntDecipher, outRoundNumber} !== {2'b11, RN_W'(0)})
      $display("FAIL dec_last: got %b_%0d expected 11_0", {outRegOutDataWr, outIntDecipher}, outRoundNumber);
    else passCount++;
    cyc(); #1;
    checkCount++;
    if ({outValid, outIntDecipher} !== 2'b11)
      $display("FAIL dec_hold: got %b expected 11", {outValid, outIntDecipher}); else passCount++;
    inOutAck = 1'b1;
    cyc(); inOutAck = 1'b0; #1;
    checkCount++;
    if (outBusy !== 1'b0) $display("FAIL dec_idle: got %b expected 0", outBusy); else passCount++;
  endtask

  task automatic test_indirect_key();
    cyc();
    inKeyWr = 1'b1; inMode = 1'b1; #1;
    checkCount++;
    if ({outResetKey, outDataWrKey, outKeyWrExt} !== 3'b110)
      $display("FAIL ikey_start: got %b expected 110", {outResetKey, outDataWrKey, outKeyWrExt}); else passCount++;
    cyc(); inKeyWr = 1'b0; inMode = 1'b0;
    for (int c = 1; c <= ROUNDS; c++) begin
      inDataWr = (c == 5); inDecipher = 1'b0; #1;
      checkCount++;
      if ({outBusy, outDataWrInt, outKeyReady, outDataWrExt, outRoundNumber} !== {4'b1100, RN_W'(c - 1)})
        $display("FAIL ikey_run%0d: got %b_%0d expected 1100_%0d", c,
                 {outBusy, outDataWrInt, outKeyReady, outDataWrExt}, outRoundNumber, c - 1);
      else passCount++;
      cyc();
    end
    inDataWr = 1'b0; #1;
    checkCount++;
    if ({outKeyWrCipher, outKeyReady, outRoundNumber} !== {2'b10, RN_W'(ROUNDS)})
      $display("FAIL ikey_last: got %b_%0d expected 10_16", {outKeyWrCipher, outKeyReady}, outRoundNumber);
    else passCount++;
    cyc(); #1;
    checkCount++;
    if ({outKeyReady, outBusy, outKeyWrCipher} !== 3'b100)
      $display("FAIL ikey_ready: got %b expected 100", {outKeyReady, outBusy, outKeyWrCipher}); else passCount++;
  endtask

  task automatic test_abort();
`ifdef NOEKEON_CTRL_ABORT_EN
    cyc();
    inKeyWr = 1'b1; inMode = 1'b1;
    cyc(); inKeyWr = 1'b0; inMode = 1'b0;
    repeat (7) cyc();
    inAbort = 1'b1; #1;
    checkCount++;
    if ({outBusy, outDataWrInt, outRoundNumber} !== {2'b10, RN_W'(7)})
      $display("FAIL abort_key_cycle: got %b_%0d expected 10_7", {outBusy, outDataWrInt}, outRoundNumber);
    else passCount++;
    cyc(); inAbort = 1'b0; #1;
    checkCount++;
    if ({outBusy, outKeyReady, outRoundNumber} !== {2'b00, RN_W'(0)})
      $display("FAIL abort_key_idle: got %b_%0d expected 00_0", {outBusy, outKeyReady}, outRoundNumber);
    else passCount++;
    for (int i = 0; i < 12; i++) begin
      checkCount++;
      if ({outKeyWrCipher, outKeyReady} !== 2'b00)
        $display("FAIL abort_key_quiet%0d: got %b expected 00", i, {outKeyWrCipher, outKeyReady}); else passCount++;
      cyc();
    end
    inKeyWr = 1'b1; inMode = 1'b0;
    cyc(); inKeyWr = 1'b0;
    inDataWr = 1'b1; inDecipher = 1'b0;
    cyc(); inDataWr = 1'b0;
    repeat (ROUNDS + 1) cyc();
    inAbort = 1'b1; #1;
    checkCount++;
    if (outValid !== 1'b1) $display("FAIL abort_hold_valid: got %b expected 1", outValid); else passCount++;
    cyc(); inAbort = 1'b0; #1;
    checkCount++;
    if ({outValid, outBusy} !== 2'b00)
      $display("FAIL abort_hold_drop: got %b expected 00", {outValid, outBusy}); else passCount++;
`else
    cyc();
    inDataWr = 1'b1; inDecipher = 1'b0;
    cyc(); inDataWr = 1'b0;
    repeat (7) cyc();
    inAbort = 1'b1; #1;
    checkCount++;
    if ({outDataWrInt, outRoundNumber} !== {1'b1, RN_W'(7)})
      $display("FAIL abort_ignored_cycle: got %b_%0d expected 1_7", outDataWrInt, outRoundNumber); else passCount++;
    cyc(); inAbort = 1'b0; #1;
    checkCount++;
    if ({outBusy, outDataWrInt, outRoundNumber} !== {2'b11, RN_W'(8)})
      $display("FAIL abort_ignored_next: got %b_%0d expected 11_8", {outBusy, outDataWrInt}, outRoundNumber);
    else passCount++;
    repeat (ROUNDS - 8 + 1) cyc();
    checkCount++;
    if (outValid !== 1'b1) $display("FAIL abort_ignored_hold: got %b expected 1", outValid); else passCount++;
    inOutAck = 1'b1;
    cyc(); inOutAck = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    cyc();
    inKeyWr = 1'b1; inMode = 1'b0;
    cyc(); inKeyWr = 1'b0;
    inDataWr = 1'b1; inDecipher = 1'b0;
    cyc(); inDataWr = 1'b0;
    repeat (7) cyc();
    inReset = 1'b1; #1;
    checkCount++;
    if ({outDataWrInt, outResetKey, outRoundNumber} !== {2'b01, RN_W'(7)})
      $display("FAIL midreset_cycle: got %b_%0d expected 01_7", {outDataWrInt, outResetKey}, outRoundNumber);
    else passCount++;
    cyc(); inReset = 1'b0; #1;
    checkCount++;
    if (allOut !== 16'h0) $display("FAIL midreset_outputs: got %h expected 0000", allOut); else passCount++;
  endtask

  initial begin
    inReset = 1'b0; inMode = 1'b0; inDecipher = 1'b0; inKeyWr = 1'b0;
    inDataWr = 1'b0; inOutAck = 1'b0; inAbort = 1'b0;
    test_reset();
    test_data_no_key();
    test_direct_key();
    test_key_priority();
    test_encrypt();
    test_decrypt();
    test_indirect_key();
    test_abort();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected finish within 200000 time units");
    $fatal(1);
  end

endmodule

// File: doc/noekeon_round_ctrl.md
# noekeon_round_ctrl

Parametrised round-sequencing controller for the Noekeon core, successor to the fixed 16-round control FSM. It drives the key register, the data register, the round function and the output register. Compared with its predecessor it adds:
- a configurable round count and counter width;
- key-readiness tracking that gates data requests;
- a valid/acknowledge output handshake with hold;
- an optional abort.

## Interface
- ROUNDS, 16, number of full rounds; legal range ≥ 2.
- RN_W, 5, round-counter width; 2**RN_W must exceed ROUNDS.
- inClk  in  1  clock; all state changes on its rising edge.
- inReset  in  1  synchronous, active-high reset.
- inMode  in  1  sampled with inKeyWr: 0 = direct key, 1 = indirect key (key encrypted under the all-zero key).
- inDecipher  in  1  sampled with inDataWr: 1 = decrypt, 0 = encrypt.
- inKeyWr  in  1  key-load request.
- inDataWr  in  1  data-load request.
- inOutAck  in  1  downstream has consumed the result.
- inAbort  in  1  cancel the current operation (effective only with the abort macro).
- outBusy  out  1  high in every state except IDLE.
- outKeyWrExt  out  1  load key register from the external bus.
- outKeyWrCipher  out  1  load key register from the data path (indirect key complete).
- outDataWrKey  out  1  load data register with the external key (indirect start).
- outDataWrExt  out  1  load data register from the external bus.
- outDataWrInt  out  1  load data register from the round function.
- outRoundNumber  out  RN_W  current round index.
- outRegOutDataWr  out  1  load output register from the final round.
- outIntDecipher  out  1  decrypt mode of the current operation.
- outResetKey  out  1  clear the key register.
- outKeyReady  out  1  a usable working key is loaded.
- outValid  out  1  output register holds an unacknowledged result.

## Operation
- States: IDLE, KEY_RUN, KEY_LAST, ENC_RUN, ENC_LAST, DEC_RUN, DEC_LAST, HOLD.
- IDLE + inKeyWr + !inMode:
  - outKeyWrExt = 1; keyReady is set on the next edge.
  - The controller stays in IDLE.
- IDLE + inKeyWr + inMode:
  - outDataWrKey = 1 and outResetKey = 1.
  - keyReady is cleared; round counter = 0; decipher = 0; next state KEY_RUN.
- IDLE + inDataWr + !inKeyWr + keyReady:
  - outDataWrExt = 1.
  - If !inDecipher: round counter = 0, next state ENC_RUN.
  - Otherwise: round counter = ROUNDS, decipher = 1, next state DEC_RUN.
- inDataWr is ignored when keyReady = 0, and also on any cycle where inKeyWr is high (inKeyWr has priority).
- Counting in the RUN states:
  - ENC_RUN and KEY_RUN increment the counter while it is < ROUNDS−1. On the edge where it equals ROUNDS−1 the counter increments and the state moves to the matching LAST state.
  - DEC_RUN decrements the counter while it is > 1. At 1 the counter decrements to 0 and the state moves to DEC_LAST.
- outDataWrInt = 1 in every RUN state.
- LAST states:
  - KEY_LAST: outKeyWrCipher = 1, keyReady set, next state IDLE.
  - ENC_LAST and DEC_LAST: outRegOutDataWr = 1, next state HOLD.
- HOLD: outValid = 1. inOutAck moves the state to IDLE; inDataWr and inKeyWr are ignored on that same cycle.
- outResetKey = inReset OR (IDLE & inKeyWr & inMode). It is combinational.
- Reset clears state to IDLE and zeroes the round counter, mode, decipher and keyReady. On the cycle after reset every output is 0.

## Timing
- A request sampled in cycle 0 produces:
  - RUN states in cycles 1..ROUNDS;
  - the LAST state in cycle ROUNDS+1;
  - outValid from cycle ROUNDS+2 through the cycle inOutAck is sampled;
  - IDLE one cycle after the ack.
- Indirect key: KEY_LAST in cycle ROUNDS+1; outKeyReady is high from cycle ROUNDS+2.
- outRoundNumber for encryption runs 0..ROUNDS−1 in RUN and equals ROUNDS in LAST. For decryption it runs ROUNDS..1 in RUN and equals 0 in LAST.
- inReset asserted mid-operation overrides everything at the next edge. No write strobe is asserted in the reset cycle except outResetKey.

## Configuration
- NOEKEON_CTRL_ABORT_EN defined:
  - inAbort high in any non-IDLE state forces IDLE and round counter 0 at the next edge.
  - All write strobes are suppressed during the abort cycle.
  - Aborting in KEY_RUN or KEY_LAST leaves keyReady = 0. Aborting in HOLD discards the result, so outValid drops.
- NOEKEON_CTRL_ABORT_EN undefined: the inAbort port remains but is ignored.

## Structure
- noekeon_pkg holds the state enum, the default ROUNDS (16) and RN_W (5), and the helper constant ROUNDS−1.
- One sub-module, noekeon_round_cnt, provides the loadable up/down RN_W counter with load, increment and decrement controls.

## Test plan
All scenarios use ROUNDS = 16.
- Direct key, then inDataWr with inDecipher = 0 → outDataWrInt high for 16 cycles with rounds 0..15, outRegOutDataWr at round 16, outValid held until inOutAck, then IDLE.
- inDataWr with inDecipher = 1 → rounds 16..1 in DEC_RUN, then round 0 with outRegOutDataWr; outIntDecipher = 1 throughout.
- inKeyWr with inMode = 1 → outResetKey and outDataWrKey in cycle 0, outKeyWrCipher in cycle 17, outKeyReady high in cycle 18. An inDataWr sent in cycle 5 is ignored (outBusy = 1).
- inDataWr after reset with no key loaded → no response, outBusy = 0. inKeyWr and inDataWr in the same cycle → only the key action occurs.
- In HOLD, withhold inOutAck for 10 cycles → outValid remains 1 and inDataWr is ignored. Assert inReset in ENC_RUN at round 7 → IDLE with all outputs 0 on the next cycle.
- With NOEKEON_CTRL_ABORT_EN: inAbort at round 7 of KEY_RUN → IDLE, outKeyReady = 0, no outKeyWrCipher.
